voice_alloc: RTL and testbench

VOICE_ALLOC -- requirements
Module: voice_alloc

---
 rtl/voice_alloc.sv | 204 ++++++++++++++++++++
 tb/tb_voice_alloc.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_alloc.sv
// rtl/voice_alloc.sv - MIDI voice allocator with per-voice phase accumulators
module voice_alloc #(
    parameter int NUM_VOICES = 16,
    parameter int PHASE_W    = 19,
    parameter int SAMPLE_DIV = 667,
    localparam int IDX_W     = $clog2(NUM_VOICES)
) (
    input  logic               clk32,
    input  logic               rst_n,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic [1:0]         ev_type,
    input  logic [6:0]         ev_note,
    input  logic [6:0]         ev_vel,
    input  logic [3:0]         ev_chan,
    output logic [6:0]         freq_note,
    input  logic [17:0]        freq_step,
    output logic               sample_tick,
    output logic               v_valid,
    output logic [IDX_W-1:0]   v_idx,
    output logic [PHASE_W-1:0] v_phase,
    output logic [6:0]         v_vel,
    output logic               v_active,
    output logic               stolen
);
    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(NUM_VOICES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);
    localparam logic [1:0] EV_ON = 2'b00, EV_OFF = 2'b01, EV_ALL = 2'b10, EV_NOP = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

    state_t             state_q;
    logic               started_q, ev_ready_q, stolen_q;
    logic [1:0]         lt_type_q;
    logic [6:0]         lt_note_q, lt_vel_q;
    logic [3:0]         lt_chan_q;
    logic [IDX_W-1:0]   scan_q;
    logic [7:0]         seq_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               retrig_q, retrig_d, free_q, free_d, old_q, old_d;
    logic [IDX_W-1:0]   retrig_idx_q, retrig_idx_d, free_idx_q, free_idx_d;
    logic [IDX_W-1:0]   old_idx_q, old_idx_d, tgt;
    logic [7:0]         old_age_q, old_age_d, cur_age;
    logic               cur_match, stolen_d;

    logic               active_q [NUM_VOICES];
    logic [6:0]         note_q   [NUM_VOICES];
    logic [3:0]         chan_q   [NUM_VOICES];
    logic [6:0]         vel_q    [NUM_VOICES];
    logic [7:0]         stamp_q  [NUM_VOICES];
    logic [PHASE_W-1:0] phase_q  [NUM_VOICES];

    logic               upd_en;
    logic [IDX_W-1:0]   upd_idx;
    logic [PHASE_W-1:0] phase_nx;

    // Candidate tracking while walking the table; age is seq-stamp mod 256.
    always_comb begin
        cur_match    = active_q[scan_q] && (note_q[scan_q] == lt_note_q) && (chan_q[scan_q] == lt_chan_q);
        cur_age      = seq_q - stamp_q[scan_q];
        retrig_d     = retrig_q;
        retrig_idx_d = retrig_idx_q;
        free_d       = free_q;
        free_idx_d   = free_idx_q;
        old_d        = old_q;
        old_idx_d    = old_idx_q;
        old_age_d    = old_age_q;
        if (!retrig_q && cur_match) begin
            retrig_d     = 1'b1;
            retrig_idx_d = scan_q;
        end
        if (!free_q && !active_q[scan_q]) begin
            free_d     = 1'b1;
            free_idx_d = scan_q;
        end
        if (active_q[scan_q] && (!old_q || (cur_age > old_age_q))) begin
            old_d     = 1'b1;
            old_idx_d = scan_q;
            old_age_d = cur_age;
        end
        stolen_d = (state_q == S_SCAN) && (scan_q == IDX_LAST) && (lt_type_q == EV_ON)
                   && !retrig_d && !free_d;
        tgt = retrig_q ? retrig_idx_q : (free_q ? free_idx_q : old_idx_q);
    end

    always_comb begin
        upd_en   = started_q && (cnt_q >= CNT_ONE) && (cnt_q <= CNT_N);
        upd_idx  = IDX_W'(cnt_q - CNT_ONE);
        phase_nx = active_q[upd_idx] ? phase_q[upd_idx] + PHASE_W'(freq_step) : phase_q[upd_idx];
    end

    assign ev_ready    = ev_ready_q;
    assign stolen      = stolen_q;
    assign sample_tick = started_q && (cnt_q == '0);
    assign freq_note   = (started_q && (cnt_q < CNT_N)) ? note_q[IDX_W'(cnt_q)] : 7'd0;
    assign v_valid     = upd_en;
    assign v_idx       = upd_en ? upd_idx : '0;
    assign v_phase     = upd_en ? phase_nx : '0;
    assign v_vel       = upd_en ? vel_q[upd_idx] : 7'd0;
    assign v_active    = upd_en && active_q[upd_idx];

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            started_q    <= 1'b0;
            ev_ready_q   <= 1'b0;
            stolen_q     <= 1'b0;
            lt_type_q    <= 2'b00;
            lt_note_q    <= 7'd0;
            lt_vel_q     <= 7'd0;
            lt_chan_q    <= 4'd0;
            scan_q       <= '0;
            seq_q        <= 8'd0;
            cnt_q        <= '0;
            retrig_q     <= 1'b0;
            free_q       <= 1'b0;
            old_q        <= 1'b0;
            retrig_idx_q <= '0;
            free_idx_q   <= '0;
            old_idx_q    <= '0;
            old_age_q    <= 8'd0;
            for (int k = 0; k < NUM_VOICES; k++) begin
                active_q[k] <= 1'b0;
                note_q[k]   <= 7'd0;
                chan_q[k]   <= 4'd0;
                vel_q[k]    <= 7'd0;
                stamp_q[k]  <= 8'd0;
                phase_q[k]  <= '0;
            end
        end else begin
            started_q <= 1'b1;
            if (started_q) begin
                cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
            end
            stolen_q <= stolen_d;

            case (state_q)
                S_IDLE: begin
                    if (ev_valid && ev_ready_q && (ev_type != EV_NOP)) begin
                        lt_type_q  <= ev_type;
                        lt_note_q  <= ev_note;
                        lt_vel_q   <= ev_vel;
                        lt_chan_q  <= ev_chan;
                        scan_q     <= '0;
                        retrig_q   <= 1'b0;
                        free_q     <= 1'b0;
                        old_q      <= 1'b0;
                        ev_ready_q <= 1'b0;
                        state_q    <= S_SCAN;
                    end else begin
                        ev_ready_q <= 1'b1;
                    end
                end
                S_SCAN: begin
                    retrig_q     <= retrig_d;
                    retrig_idx_q <= retrig_idx_d;
                    free_q       <= free_d;
                    free_idx_q   <= free_idx_d;
                    old_q        <= old_d;
                    old_idx_q    <= old_idx_d;
                    old_age_q    <= old_age_d;
                    scan_q       <= scan_q + IDX_W'(1);
                    if (scan_q == IDX_LAST) begin
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    ev_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                    if (lt_type_q == EV_ON) begin
                        seq_q <= seq_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Commit writes follow the scan update so a same-voice collision resets phase.
            for (int k = 0; k < NUM_VOICES; k++) begin
                if (upd_en && (upd_idx == IDX_W'(k))) begin
                    phase_q[k] <= phase_nx;
                end
                if (state_q == S_COMMIT) begin
                    if ((lt_type_q == EV_ON) && (tgt == IDX_W'(k))) begin
                        active_q[k] <= 1'b1;
                        note_q[k]   <= lt_note_q;
                        chan_q[k]   <= lt_chan_q;
                        vel_q[k]    <= lt_vel_q;
                        stamp_q[k]  <= seq_q;
                        phase_q[k]  <= '0;
                    end else if ((lt_type_q == EV_OFF) && active_q[k]
                                 && (note_q[k] == lt_note_q) && (chan_q[k] == lt_chan_q)) begin
                        active_q[k] <= 1'b0;
                    end else if ((lt_type_q == EV_ALL) && (chan_q[k] == lt_chan_q)) begin
                        active_q[k] <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_voice_alloc.sv
// tb/tb_voice_alloc.sv - scoreboard bench for voice_alloc against an event-level model
module tb_voice_alloc;
    localparam int N   = 16;
    localparam int DIV = 667;

    logic        clk32, rst_n, ev_valid, ev_ready;
    logic [1:0]  ev_type;
    logic [6:0]  ev_note, ev_vel, freq_note, v_vel;
    logic [3:0]  ev_chan, v_idx;
    logic [17:0] freq_step;
    logic        sample_tick, v_valid, v_active, stolen;
    logic [18:0] v_phase;

    voice_alloc #(.NUM_VOICES(N), .PHASE_W(19), .SAMPLE_DIV(DIV)) dut (
        .clk32(clk32), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_type(ev_type), .ev_note(ev_note), .ev_vel(ev_vel), .ev_chan(ev_chan),
        .freq_note(freq_note), .freq_step(freq_step), .sample_tick(sample_tick),
        .v_valid(v_valid), .v_idx(v_idx), .v_phase(v_phase), .v_vel(v_vel),
        .v_active(v_active), .stolen(stolen)
    );

    initial clk32 = 1'b0;
    always #5 clk32 = ~clk32;

    typedef struct packed {
        logic ready; logic tick; logic [6:0] fn; logic st; logic vv;
        logic [3:0] idx; logic [18:0] ph; logic [6:0] vel; logic act;
    } rec_t;
    rec_t exp_q[$];

    int checks = 0, passes = 0, stolen_cnt = 0;
    int ftab[128];
    bit override = 1'b0;
    logic [6:0] fn_cap = 7'd0;
    int snap_act[N], snap_vel[N], snap_ph[N];

    int m_active[N], m_note[N], m_chan[N], m_vel[N], m_stamp[N], m_phase[N];
    int m_seq, m_cnt, m_wait, p_type, p_note, p_vel, p_chan;
    bit m_started;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic timeout(input string name);
        checks++;
        $display("FAIL %s: bound expired waiting for DUT, required event never seen", name);
    endtask

    // External frequency table: answers one cycle after freq_note.
    always @(negedge clk32) fn_cap = freq_note;
    always @(posedge clk32) begin
        #1;
        freq_step = override ? 18'h3FFFF : 18'(ftab[fn_cap]);
    end

    always @(negedge clk32) if (stolen) stolen_cnt++;

    task automatic model_reset();
        for (int v = 0; v < N; v++) begin
            m_active[v] = 0; m_note[v] = 0; m_chan[v] = 0;
            m_vel[v] = 0; m_stamp[v] = 0; m_phase[v] = 0;
        end
        m_seq = 0; m_cnt = 0; m_wait = 0; m_started = 1'b0;
    endtask

    task automatic model_commit(output bit st);
        int tgt, best, age;
        st = 1'b0;
        if (p_type == 0) begin
            tgt = -1;
            for (int v = 0; v < N; v++)
                if (tgt < 0 && m_active[v] != 0 && m_note[v] == p_note && m_chan[v] == p_chan) tgt = v;
            for (int v = 0; v < N; v++)
                if (tgt < 0 && m_active[v] == 0) tgt = v;
            if (tgt < 0) begin
                best = -1;
                for (int v = 0; v < N; v++) begin
                    age = (m_seq - m_stamp[v]) & 255;
                    if (age > best) begin best = age; tgt = v; end
                end
                st = 1'b1;
            end
            m_active[tgt] = 1; m_note[tgt] = p_note; m_chan[tgt] = p_chan;
            m_vel[tgt] = p_vel; m_stamp[tgt] = m_seq; m_phase[tgt] = 0;
            m_seq = (m_seq + 1) % 256;
        end else if (p_type == 1) begin
            for (int v = 0; v < N; v++)
                if (m_active[v] != 0 && m_note[v] == p_note && m_chan[v] == p_chan) m_active[v] = 0;
        end else if (p_type == 2) begin
            for (int v = 0; v < N; v++)
                if (m_chan[v] == p_chan) m_active[v] = 0;
        end
    endtask

    // Reference model: computes this cycle's expected outputs, then advances to the next edge.
    always @(negedge clk32) begin
        rec_t e;
        int k;
        bit st;
        e = '0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1'b1;
        end else begin
            e.ready = (m_wait == 0);
            e.tick  = (m_cnt == 0);
            e.fn    = (m_cnt < N) ? 7'(m_note[m_cnt]) : 7'd0;
            if (m_cnt >= 1 && m_cnt <= N) begin
                k = m_cnt - 1;
                if (m_active[k] != 0) m_phase[k] = (m_phase[k] + int'(freq_step)) % (1 << 19);
                e.vv = 1'b1; e.idx = 4'(k); e.ph = 19'(m_phase[k]);
                e.vel = 7'(m_vel[k]); e.act = (m_active[k] != 0);
            end
            if (m_wait == 1) begin
                model_commit(st);
                e.st = st;
            end
            if (m_wait > 0) m_wait--;
            else if (ev_valid && ev_type != 2'b11) begin
                p_type = ev_type; p_note = ev_note; p_vel = ev_vel; p_chan = ev_chan;
                m_wait = N + 1;
            end
            m_cnt = (m_cnt + 1) % DIV;
        end
        exp_q.push_back(e);
    end

    // Monitor: pops the expected record for every cycle and compares the DUT outputs.
    always @(negedge clk32) begin
        rec_t a, e;
        #1;
        if (exp_q.size() == 0) begin
            timeout("scoreboard_underflow");
        end else begin
            e = exp_q.pop_front();
            a = {ev_ready, sample_tick, freq_note, stolen, v_valid, v_idx, v_phase, v_vel, v_active};
            if (!e.vv) begin a.idx = '0; a.ph = '0; a.vel = '0; a.act = 1'b0; end
            checks++;
            if (a == e) passes++;
            else $display("FAIL cycle_outputs @%0t: got rdy=%0b tick=%0b fn=%0d st=%0b vv=%0b idx=%0d ph=%h vel=%0d act=%0b, required rdy=%0b tick=%0b fn=%0d st=%0b vv=%0b idx=%0d ph=%h vel=%0d act=%0b",
                          $time, a.ready, a.tick, a.fn, a.st, a.vv, a.idx, a.ph, a.vel, a.act,
                          e.ready, e.tick, e.fn, e.st, e.vv, e.idx, e.ph, e.vel, e.act);
        end
    end

    task automatic do_reset();
        @(posedge clk32); #1 rst_n = 1'b0;
        #1;
        chk("rst_ev_ready", ev_ready, 0);
        chk("rst_outputs", {sample_tick, v_valid, stolen, freq_note, v_phase}, 0);
        repeat (3) @(posedge clk32);
        #1 rst_n = 1'b1;
        @(negedge clk32);
        chk("pre_first_edge_ready", ev_ready, 0);
        @(negedge clk32);
        chk("first_cycle_tick", sample_tick, 1);
        chk("first_cycle_ready", ev_ready, 1);
        stolen_cnt = 0;
    endtask

    task automatic send(input logic [1:0] t, input logic [6:0] n, input logic [6:0] v, input logic [3:0] c);
        int guard = 0;
        @(posedge clk32); #1;
        ev_valid = 1'b1; ev_type = t; ev_note = n; ev_vel = v; ev_chan = c;
        do begin @(negedge clk32); guard++; end while (!ev_ready && guard < 100);
        if (!ev_ready) timeout("send_handshake");
        @(posedge clk32); #1 ev_valid = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        do begin @(negedge clk32); lat++; end while (!ev_ready && lat < 200);
        if (!ev_ready) timeout("wait_ready");
    endtask

    task automatic snapshot();
        int guard = 0;
        do begin @(negedge clk32); guard++; end while (!(v_valid && v_idx == 4'd0) && guard < 2 * DIV);
        if (guard >= 2 * DIV) timeout("snapshot_start");
        for (int i = 0; i < N; i++) begin
            snap_act[i] = v_active; snap_vel[i] = v_vel; snap_ph[i] = v_phase;
            if (i < N - 1) @(negedge clk32);
        end
    endtask

    function automatic int active_count();
        int s = 0;
        for (int i = 0; i < N; i++) s += snap_act[i];
        return s;
    endfunction

    initial begin
        int lat, seen, ph, guard;
        for (int i = 0; i < 128; i++) ftab[i] = $urandom_range(1, 262143);
        ev_valid = 1'b0; ev_type = 2'b00; ev_note = 7'd0; ev_vel = 7'd0; ev_chan = 4'd0;
        freq_step = 18'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        do_reset();

        // Single note-on, then retrigger of the same note/channel.
        send(2'b00, 7'd60, 7'd100, 4'd0);
        wait_ready(lat);
        chk("accept_to_ready", lat, N + 2);
        snapshot();
        chk("on_act0", snap_act[0], 1);
        chk("on_vel0", snap_vel[0], 100);
        chk("on_phase0", snap_ph[0], ftab[60]);
        chk("on_act1", snap_act[1], 0);
        send(2'b00, 7'd60, 7'd90, 4'd0);
        wait_ready(lat);
        snapshot();
        chk("retrig_vel0", snap_vel[0], 90);
        chk("retrig_phase0", snap_ph[0], ftab[60]);
        chk("retrig_count", active_count(), 1);

        // Note-off and all-notes-off by channel.
        do_reset();
        send(2'b00, 7'd60, 7'd10, 4'd0);
        send(2'b00, 7'd60, 7'd11, 4'd1);
        send(2'b01, 7'd60, 7'd0, 4'd0);
        wait_ready(lat);
        snapshot();
        chk("off_act0", snap_act[0], 0);
        chk("off_act1", snap_act[1], 1);
        send(2'b10, 7'd0, 7'd0, 4'd1);
        wait_ready(lat);
        snapshot();
        chk("alloff_count", active_count(), 0);

        // Seventeen note-ons: the last steals the oldest voice.
        do_reset();
        for (int i = 0; i < 17; i++) send(2'b00, 7'(20 + i), 7'(i + 1), 4'd0);
        wait_ready(lat);
        chk("steal_pulses", stolen_cnt, 1);
        snapshot();
        chk("steal_count", active_count(), N);
        chk("steal_vel0", snap_vel[0], 17);
        chk("steal_vel15", snap_vel[15], 16);

        // Maximum step accumulated over three samples wraps modulo 2^19.
        do_reset();
        override = 1'b1;
        send(2'b00, 7'd5, 7'd50, 4'd2);
        wait_ready(lat);
        seen = 0; ph = 0; guard = 0;
        while (seen < 3 && guard < 4 * DIV) begin
            @(negedge clk32); guard++;
            if (v_valid && v_idx == 4'd0 && v_active) begin seen++; ph = v_phase; end
        end
        if (seen < 3) timeout("wrap_samples");
        chk("phase_wrap", ph, (3 * 262143) % 524288);
        override = 1'b0;

        // Reset while the control FSM is scanning drops the event.
        do_reset();
        send(2'b00, 7'd60, 7'd100, 4'd0);
        repeat (3) @(posedge clk32);
        do_reset();
        repeat (20) @(negedge clk32);
        snapshot();
        chk("midscan_reset_count", active_count(), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 250; i++) begin
            int r;
            logic [1:0] t;
            r = $urandom_range(0, 9);
            t = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            send(t, 7'(40 + $urandom_range(0, 11)), 7'($urandom_range(0, 127)), 4'($urandom_range(0, 2)));
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 40)) @(posedge clk32);
        end
        wait_ready(lat);
        snapshot();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
